// File: rtl/vx_stream_demux.sv
// -----------------------------------------------------------------------------
// vx_stream_demux
//
// Steers one valid/ready input stream to one of NUM_OUTS output streams, chosen
// per transfer by sel_in. This is the fan-out partner of the fixed-priority
// arbiter. A typical use is routing memory or cache responses back to the
// requester that issued them.
//
// BUFFERED=1: each lane owns a 2-entry elastic buffer.
//   - Outputs come straight from registers.
//   - Each lane sustains one transfer per cycle.
//   - A stalled lane never blocks traffic bound for other lanes.
//   - ready_in depends only on sel_in and registered lane state; it has no
//     combinational path from ready_out.
// BUFFERED=0: purely combinational steering with zero latency.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset (clears all lane buffers)
//   valid_in   input transfer valid
//   data_in    input payload (DATAW bits)
//   sel_in     destination lane index (ignored when NUM_OUTS == 1)
//   ready_in   input accepted when valid_in && ready_in
//   valid_out  per-lane output valid
//   data_out   per-lane payload, lane i at [i*DATAW +: DATAW]
//   ready_out  per-lane downstream ready
//   count_out  per-lane occupancy (0..2), lane i at [i*2 +: 2]; 0 if unbuffered
//
// A sel_in value >= NUM_OUTS is a protocol violation. Such a transfer is
// accepted and dropped, so the input can never deadlock on it.
// -----------------------------------------------------------------------------
module vx_stream_demux #(
    parameter int NUM_OUTS     = 4,
    parameter int DATAW        = 32,
    parameter int BUFFERED     = 1,
    parameter int LOG_NUM_OUTS = $clog2(NUM_OUTS)
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             valid_in,
    input  logic [DATAW-1:0]                                 data_in,
    input  logic [((LOG_NUM_OUTS > 0) ? LOG_NUM_OUTS : 1)-1:0] sel_in,
    output logic                                             ready_in,
    output logic [NUM_OUTS-1:0]                              valid_out,
    output logic [NUM_OUTS*DATAW-1:0]                        data_out,
    input  logic [NUM_OUTS-1:0]                              ready_out,
    output logic [NUM_OUTS*2-1:0]                            count_out
);

    localparam int SELW = (LOG_NUM_OUTS > 0) ? LOG_NUM_OUTS : 1;

    // One-hot decode of the destination.
    // With a single lane, sel_in is ignored and lane 0 always receives.
    logic [NUM_OUTS-1:0] lane_sel;
    logic                sel_in_range;

    generate
        if (NUM_OUTS == 1) begin : g_single
            assign lane_sel     = 1'b1;
            assign sel_in_range = 1'b1;
        end else begin : g_multi
            for (genvar gi = 0; gi < NUM_OUTS; gi++) begin : g_dec
                assign lane_sel[gi] = (sel_in == SELW'(gi));
            end
            assign sel_in_range = ({1'b0, sel_in} < (SELW+1)'(NUM_OUTS));
        end
    endgenerate

    generate
        if (BUFFERED != 0) begin : g_buf
            logic [NUM_OUTS-1:0] lane_ready;

            // An out-of-range select is always "ready", so the bad beat is
            // swallowed instead of stalling the input forever.
            assign ready_in = !reset && (!sel_in_range || (|(lane_sel & lane_ready)));

            for (genvar gi = 0; gi < NUM_OUTS; gi++) begin : g_lane
                logic [DATAW-1:0] head_reg, head_next;
                logic [DATAW-1:0] tail_reg, tail_next;
                logic [1:0]       count_reg, count_next;
                logic             push;
                logic             pop;

                assign push = valid_in && ready_in && sel_in_range && lane_sel[gi];
                assign pop  = valid_out[gi] && ready_out[gi];

                // head_reg always holds the oldest entry and drives the output.
                // tail_reg holds the second entry when the lane is full.
                always_comb begin
                    head_next  = head_reg;
                    tail_next  = tail_reg;
                    count_next = count_reg;
                    case ({push, pop})
                        2'b10: begin
                            if (count_reg == 2'd0) begin
                                head_next = data_in;
                            end else begin
                                tail_next = data_in;
                            end
                            count_next = count_reg + 2'd1;
                        end
                        2'b01: begin
                            head_next  = tail_reg;
                            count_next = count_reg - 2'd1;
                        end
                        2'b11: begin
                            // Occupancy is unchanged.
                            // With one entry, the new beat moves straight to head.
                            // Otherwise tail advances and the new beat queues behind it.
                            if (count_reg == 2'd1) begin
                                head_next = data_in;
                            end else begin
                                head_next = tail_reg;
                                tail_next = data_in;
                            end
                        end
                        default: ;
                    endcase
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        count_reg <= 2'd0;
                    end else begin
                        count_reg <= count_next;
                    end
                end

                // Payload registers need no reset; validity comes from count_reg.
                always_ff @(posedge clk) begin
                    head_reg <= head_next;
                    tail_reg <= tail_next;
                end

                assign lane_ready[gi]              = (count_reg != 2'd2);
                assign valid_out[gi]               = (count_reg != 2'd0);
                assign data_out[gi*DATAW +: DATAW] = head_reg;
                assign count_out[gi*2 +: 2]        = count_reg;

                a_count_max : assert property (@(posedge clk) disable iff (reset)
                    count_reg <= 2'd2);
            end
        end else begin : g_nobuf
            assign ready_in  = !sel_in_range || (|(lane_sel & ready_out));
            assign valid_out = lane_sel & {NUM_OUTS{valid_in && sel_in_range}};
            assign data_out  = {NUM_OUTS{data_in}};
            assign count_out = '0;
        end
    endgenerate

    // Input-side protocol checks.
    a_sel_range : assert property (@(posedge clk) disable iff (reset)
        valid_in |-> sel_in_range);
    a_valid_hold : assert property (@(posedge clk) disable iff (reset)
        (valid_in && !ready_in) |=> valid_in);
    a_data_hold : assert property (@(posedge clk) disable iff (reset)
        (valid_in && !ready_in) |=> ($stable(data_in) && $stable(sel_in)));

endmodule

// File: tb/tb_vx_stream_demux.sv
// -----------------------------------------------------------------------------
// Self-checking bench for vx_stream_demux (NUM_OUTS=4, DATAW=32, BUFFERED=1).
//
// Stimulus pushes the expected payload into a per-lane queue when a transfer
// is accepted. A separate monitor pops that queue and compares it on every
// output handshake. Directed checks cover latency, occupancy and ready_in.
// -----------------------------------------------------------------------------
module tb_vx_stream_demux;

    localparam int NUM_OUTS = 4;
    localparam int DATAW    = 32;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      valid_in;
    logic [DATAW-1:0]          data_in;
    logic [1:0]                sel_in;
    logic                      ready_in;
    logic [NUM_OUTS-1:0]       valid_out;
    logic [NUM_OUTS*DATAW-1:0] data_out;
    logic [NUM_OUTS-1:0]       ready_out;
    logic [NUM_OUTS*2-1:0]     count_out;

    int checks = 0;
    int errors = 0;

    logic [DATAW-1:0] exp_q [NUM_OUTS][$];

    vx_stream_demux #(
        .NUM_OUTS (NUM_OUTS),
        .DATAW    (DATAW),
        .BUFFERED (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sel_in    (sel_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_out (ready_out),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one beat and hold it until accepted.
    // Returns the number of cycles spent waiting on ready_in.
    task automatic send(input int lane, input logic [DATAW-1:0] d, output int waits);
        valid_in = 1'b1;
        sel_in   = 2'(lane);
        data_in  = d;
        waits    = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready_in) break;
            waits++;
        end
        if (!ready_in) begin
            $display("FAIL send_timeout: lane %0d got ready_in=0 expected 1", lane);
            $fatal(1, "send timeout");
        end
        exp_q[lane].push_back(d);
        $display("push lane %0d data %h", lane, d);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: check every output handshake against the scoreboard.
    initial begin
        logic [DATAW-1:0] exp;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int i = 0; i < NUM_OUTS; i++) begin
                    if (valid_out[i] && ready_out[i]) begin
                        if (exp_q[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_out: lane %0d got %h expected nothing",
                                     i, data_out[i*DATAW +: DATAW]);
                        end else begin
                            exp = exp_q[i].pop_front();
                            $display("pop  lane %0d data %h", i, data_out[i*DATAW +: DATAW]);
                            chk($sformatf("lane%0d_data", i), 64'(data_out[i*DATAW +: DATAW]), 64'(exp));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        sel_in    = '0;
        ready_out = 4'hF;

        // ---- reset then idle ----
        tick();
        chk("ready_in_in_reset", 64'(ready_in), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset_valid_out", 64'(valid_out), 64'h0);
        chk("reset_count_out", 64'(count_out), 64'h0);
        // Probe ready_in for every sel, then drop valid before the next edge.
        for (int s = 0; s < NUM_OUTS; s++) begin
            valid_in = 1'b1;
            sel_in   = 2'(s);
            #1;
            chk($sformatf("idle_ready_sel%0d", s), 64'(ready_in), 64'd1);
        end
        valid_in = 1'b0;
        tick();

        // ---- single push ----
        send(2, 32'hA5, w);
        chk("single_valid_out", 64'(valid_out), 64'h4);
        chk("single_data", 64'(data_out[2*DATAW +: DATAW]), 64'hA5);
        chk("single_count", 64'(count_out), 64'h10);
        tick();
        chk("single_empty", 64'(valid_out), 64'h0);

        // ---- backpressure isolation ----
        ready_out = 4'b1101;
        send(1, 32'h11, w);
        send(1, 32'h22, w);
        chk("bp_count_full", 64'(count_out), 64'h08);
        chk("bp_valid_out", 64'(valid_out), 64'h2);
        sel_in = 2'd1;
        #1;
        chk("bp_ready_sel1", 64'(ready_in), 64'd0);
        send(3, 32'h33, w);
        chk("bp_lane3_wait", 64'(w), 64'd0);
        chk("bp_valid_lane3", 64'(valid_out), 64'hA);
        chk("bp_lane3_data", 64'(data_out[3*DATAW +: DATAW]), 64'h33);
        tick();
        ready_out = 4'hF;
        chk("bp_head_first", 64'(data_out[1*DATAW +: DATAW]), 64'h11);
        tick();
        chk("bp_head_second", 64'(data_out[1*DATAW +: DATAW]), 64'h22);
        chk("bp_count_one", 64'(count_out), 64'h04);
        tick();
        chk("bp_drained", 64'(valid_out), 64'h0);

        // ---- streaming to lane 0 ----
        for (int k = 0; k < 8; k++) begin
            send(0, 32'h100 + 32'(k), w);
            chk($sformatf("stream_wait%0d", k), 64'(w), 64'd0);
            chk($sformatf("stream_head%0d", k), 64'(data_out[0 +: DATAW]), 64'h100 + 64'(k));
        end
        tick();
        chk("stream_drained", 64'(count_out), 64'h0);

        // ---- simultaneous push/pop with one entry ----
        ready_out = 4'b1110;
        send(0, 32'hAA, w);
        chk("pp_count_before", 64'(count_out), 64'h01);
        ready_out = 4'hF;
        send(0, 32'hBB, w);
        chk("pp_count_after", 64'(count_out), 64'h01);
        chk("pp_head_new", 64'(data_out[0 +: DATAW]), 64'hBB);
        tick();
        chk("pp_drained", 64'(valid_out), 64'h0);

        // ---- reset mid-operation with lanes 0 and 3 full ----
        ready_out = 4'b0110;
        send(0, 32'h1, w);
        send(0, 32'h2, w);
        send(3, 32'h3, w);
        send(3, 32'h4, w);
        chk("mid_count_full", 64'(count_out), 64'h82);
        reset = 1'b1;
        exp_q[0].delete();
        exp_q[3].delete();
        #1;
        chk("mid_ready_in_reset", 64'(ready_in), 64'd0);
        tick();
        reset     = 1'b0;
        ready_out = 4'hF;
        #1;
        chk("mid_valid_out", 64'(valid_out), 64'h0);
        chk("mid_count_out", 64'(count_out), 64'h0);
        send(2, 32'h5A, w);
        chk("mid_push_valid", 64'(valid_out), 64'h4);
        chk("mid_push_data", 64'(data_out[2*DATAW +: DATAW]), 64'h5A);
        tick();
        chk("mid_push_empty", 64'(valid_out), 64'h0);

        // ---- every expected beat must have been seen ----
        tick();
        tick();
        for (int i = 0; i < NUM_OUTS; i++) begin
            chk($sformatf("leftover_lane%0d", i), 64'(exp_q[i].size()), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
